// File: rtl/nic_if_if.sv
// PE register bus and router PE-port handshake bundle for nic_if.
// The slave modport is the NIC's view; the master modport is the PE/router side.
interface nic_if_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  // PE register access
  logic [1:0]            addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  nicEn;
  logic                  nicWrEn;
  // Injection (NIC -> router)
  logic                  net_so;
  logic                  net_ro;
  logic [DATA_WIDTH-1:0] net_do;
  logic                  net_polarity;
  // Ejection (router -> NIC)
  logic                  net_si;
  logic                  net_ri;
  logic [DATA_WIDTH-1:0] net_di;

  modport slave (
    input  addr, d_in, nicEn, nicWrEn,
    input  net_ro, net_polarity, net_si, net_di,
    output d_out, net_so, net_do, net_ri
  );

  modport master (
    output addr, d_in, nicEn, nicWrEn,
    output net_ro, net_polarity, net_si, net_di,
    input  d_out, net_so, net_do, net_ri
  );
endinterface

// File: rtl/nic_if.sv
// Network interface controller: register-mapped one-packet input and output
// buffers between a processing element and the router's PE port.
module nic_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned VC_BIT     = 63
) (
  input logic        clk,
  input logic        reset,
  nic_if_if.slave    bus
);

  localparam logic [1:0] ADDR_IN_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IN_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_OUT_DATA   = 2'd2;
  localparam logic [1:0] ADDR_OUT_STATUS = 2'd3;

  logic [DATA_WIDTH-1:0] in_buf;
  logic [DATA_WIDTH-1:0] out_buf;
  logic [DATA_WIDTH-1:0] d_out_q;
  logic                  in_full;
  logic                  out_full;
  logic                  pe_rd;
  logic                  pe_wr;
  logic                  send;

  assign pe_rd = bus.nicEn & ~bus.nicWrEn;
  assign pe_wr = bus.nicEn &  bus.nicWrEn;

  // Reset gating keeps the handshake outputs at their idle values while
  // reset is held, even before the reset edge has cleared the buffers.
  assign send        = ~reset & out_full & bus.net_ro
                     & (out_buf[VC_BIT] == bus.net_polarity);
  assign bus.net_so  = send;
  assign bus.net_ri  = reset | ~in_full;
  assign bus.net_do  = out_buf;
  assign bus.d_out   = d_out_q;

  // Registered PE read data; holds when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q <= '0;
    end else if (pe_rd) begin
      case (bus.addr)
        ADDR_IN_DATA:    d_out_q <= in_buf;
        ADDR_IN_STATUS:  d_out_q <= {{(DATA_WIDTH-1){1'b0}}, in_full};
        ADDR_OUT_STATUS: d_out_q <= {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:         d_out_q <= '0;
      endcase
    end
  end

  // Ejection buffer: capture from router when empty, free on PE data read.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf  <= '0;
      in_full <= 1'b0;
    end else if (pe_rd && bus.addr == ADDR_IN_DATA && in_full) begin
      in_full <= 1'b0;
    end else if (bus.net_si && !in_full) begin
      in_buf  <= bus.net_di;
      in_full <= 1'b1;
    end
  end

  // Injection buffer: load on PE write when empty, free when sent.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_buf  <= '0;
      out_full <= 1'b0;
    end else if (send) begin
      out_full <= 1'b0;
    end else if (pe_wr && bus.addr == ADDR_OUT_DATA && !out_full) begin
      out_buf  <= bus.d_in;
      out_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nic_if.sv
// Scoreboard bench for nic_if: a driver applies directed and random stimulus
// and predicts outputs from a transaction-level model; a monitor compares.
module tb_nic_if;

  typedef struct {
    logic        so;
    logic        ri;
    logic [63:0] dat;
  } cyc_t;

  logic clk;
  logic reset;
  logic armed;
  logic rd_prev;
  logic pol;

  int n_checks;
  int n_fail;

  cyc_t        cyc_q[$];
  logic [63:0] rd_q[$];

  // Reference model: one-slot mailboxes for each direction
  logic [63:0] rx_pkt[$];
  logic [63:0] rx_last;
  logic [63:0] tx_pkt[$];
  logic [63:0] tx_last;

  nic_if_if #(.DATA_WIDTH(64)) bus ();

  nic_if #(.DATA_WIDTH(64), .VC_BIT(63)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    rd_prev <= armed & (reset | (bus.nicEn & ~bus.nicWrEn));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare combinational outputs every cycle and read data when due
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      cyc_t e;
      e = cyc_q.pop_front();
      chk("net_so", {63'b0, bus.net_so}, {63'b0, e.so});
      chk("net_ri", {63'b0, bus.net_ri}, {63'b0, e.ri});
      chk("net_do", bus.net_do, e.dat);
    end
    if (rd_prev) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL d_out: read data appeared with no expectation queued");
      end else begin
        chk("d_out", bus.d_out, rd_q.pop_front());
      end
    end
  end

  // One cycle: drive inputs, predict this cycle's outputs and next state.
  task automatic step(input bit rst, input bit en, input bit wr, input logic [1:0] a,
                      input logic [63:0] din, input bit ro, input bit si,
                      input logic [63:0] di);
    cyc_t e;
    bit   sent;
    pol = ~pol;
    reset            = rst;
    bus.nicEn        = en;
    bus.nicWrEn      = wr;
    bus.addr         = a;
    bus.d_in         = din;
    bus.net_ro       = ro;
    bus.net_si       = si;
    bus.net_di       = di;
    bus.net_polarity = pol;

    sent  = !rst && tx_pkt.size() == 1 && ro && (tx_last[63] == pol);
    e.so  = sent;
    e.ri  = rst || rx_pkt.size() == 0;
    e.dat = tx_last;
    cyc_q.push_back(e);

    if (rst) begin
      rx_pkt.delete();
      tx_pkt.delete();
      rx_last = '0;
      tx_last = '0;
      rd_q.push_back('0);
    end else begin
      if (en && !wr) begin
        case (a)
          2'd0: rd_q.push_back(rx_last);
          2'd1: rd_q.push_back(64'(rx_pkt.size()));
          2'd2: rd_q.push_back('0);
          default: rd_q.push_back(64'(tx_pkt.size()));
        endcase
      end
      if (en && !wr && a == 2'd0 && rx_pkt.size() == 1)
        void'(rx_pkt.pop_front());
      else if (si && rx_pkt.size() == 0) begin
        rx_pkt.push_back(di);
        rx_last = di;
      end
      if (sent)
        void'(tx_pkt.pop_front());
      else if (en && wr && a == 2'd2 && tx_pkt.size() == 0) begin
        tx_pkt.push_back(din);
        tx_last = din;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input bit ro);
    step(0, 1, 0, a, '0, ro, 0, '0);
  endtask

  task automatic idle(input bit ro);
    step(0, 0, 0, 2'd0, '0, ro, 0, '0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    armed    = 1'b0;
    pol      = 1'b0;
    reset    = 1'b1;
    bus.nicEn = 1'b0; bus.nicWrEn = 1'b0; bus.addr = 2'd0; bus.d_in = '0;
    bus.net_ro = 1'b0; bus.net_si = 1'b0; bus.net_di = '0; bus.net_polarity = 1'b0;
    rx_last = '0;
    tx_last = '0;
    @(posedge clk);
    #1;
    armed = 1'b1;

    // Status after reset
    rd(2'd1, 0);
    rd(2'd3, 0);
    idle(0);

    // VC-bit-1 packet waits for polarity 1
    step(0, 1, 1, 2'd2, 64'h8000_0000_0000_00AA, 1, 0, '0);
    idle(1); idle(1); idle(1);
    rd(2'd3, 1);
    idle(1);

    // Second write dropped while full; VC-bit-0 packet sends on polarity 0
    step(0, 1, 1, 2'd2, 64'h1, 0, 0, '0);
    step(0, 1, 1, 2'd2, 64'h2, 0, 0, '0);
    rd(2'd3, 0);
    idle(0);
    idle(1); idle(1); idle(1);

    // Ejection capture and PE read
    step(0, 0, 0, 2'd0, '0, 0, 1, 64'h1234);
    rd(2'd1, 0);
    rd(2'd0, 0);
    idle(0);
    rd(2'd1, 0);

    // Router send while full is ignored
    step(0, 0, 0, 2'd0, '0, 0, 1, 64'h1234);
    step(0, 0, 0, 2'd0, '0, 0, 1, 64'h55);
    rd(2'd0, 0);
    idle(0);

    // Read of addr 0 coinciding with a router send: no capture
    step(0, 0, 0, 2'd0, '0, 0, 1, 64'h99);
    step(0, 1, 0, 2'd0, '0, 0, 1, 64'h77);
    rd(2'd1, 0);
    idle(0);

    // Reset with both buffers full
    step(0, 1, 1, 2'd2, 64'h3, 0, 1, 64'h66);
    step(1, 1, 0, 2'd1, '0, 1, 0, '0);
    rd(2'd1, 1);
    rd(2'd3, 1);
    idle(1);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      bit          r_rst;
      bit          r_en;
      bit          r_wr;
      logic [1:0]  r_a;
      logic [63:0] r_d;
      logic [63:0] r_di;
      r_rst = ($urandom_range(0, 99) < 2);
      r_en  = ($urandom_range(0, 99) < 70);
      r_wr  = $urandom_range(0, 1);
      r_a   = 2'($urandom_range(0, 3));
      r_d   = {$urandom, $urandom};
      r_di  = {$urandom, $urandom};
      step(r_rst, r_en, r_wr, r_a, r_d, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 30), r_di);
    end
    idle(0);
    idle(0);
    @(negedge clk);
    #1;
    chk("drain", 64'(cyc_q.size() + rd_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nic_if.md
Name: nic_if

Overview:
- Network interface controller between a processing element (PE) and the PE port of the mesh router.
- Provides a register-mapped view of two one-packet channel buffers:
  - output buffer: PE to router injection;
  - input buffer: router to PE ejection.
- Injection follows the router's even/odd polarity virtual-channel scheme. Ejection uses the router's send/ready handshake.

Parameters:
- DATA_WIDTH, 64, packet/flit width in bits.
- VC_BIT, 63, index of the virtual-channel bit inside a packet.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- addr  input  2  PE register select.
- d_in  input  DATA_WIDTH  PE write data.
- d_out  output  DATA_WIDTH  PE read data, registered.
- nicEn  input  1  PE access enable.
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn.
- net_so  output  1  send to router PE input port.
- net_ro  input  1  router PE input port ready.
- net_do  output  DATA_WIDTH  packet to router.
- net_polarity  input  1  router polarity (toggles every cycle).
- net_si  input  1  router PE output port send.
- net_ri  output  1  NIC ready to accept from router.
- net_di  input  DATA_WIDTH  packet from router.

Behaviour:
- Register map:
  - addr 0: input buffer data (read-only).
  - addr 1: input status, bit0 = in_full, upper bits 0 (read-only).
  - addr 2: output buffer data (write-only).
  - addr 3: output status, bit0 = out_full, upper bits 0 (read-only).
- Reset: in_full=0, out_full=0, in_buf=0, out_buf=0, d_out=0. Hence net_so=0 and net_ri=1.
- PE read (nicEn=1, nicWrEn=0):
  - d_out is loaded at the clock edge with the selected register and appears the cycle after the request.
  - Reading addr 2 returns 0.
  - With nicEn=0, d_out holds its previous value.
- Reading addr 0 with in_full=1 sets in_full<=0 at the same edge. Reading addr 0 with in_full=0 returns stale in_buf and changes no state.
- PE write (nicEn=1, nicWrEn=1):
  - addr 2 with out_full=0: out_buf<=d_in, out_full<=1.
  - addr 2 with out_full=1: write is dropped, no state change.
  - Writes to addr 0, 1 and 3 are ignored.
- Ejection:
  - net_ri = ~in_full, combinational from the register.
  - net_si=1 and in_full=0 at an edge: in_buf<=net_di, in_full<=1.
  - net_si while in_full=1 is a protocol violation by the router; the NIC ignores it and keeps in_buf.
- Injection:
  - net_do = out_buf, always.
  - net_so = out_full & net_ro & (out_buf[VC_BIT] == net_polarity), combinational.
  - The transfer happens in the cycle net_so=1; out_full<=0 at that edge.
  - A VC mismatch waits at most 1 cycle, since polarity alternates.
- Simultaneous events:
  - Read of addr 0 while net_si=1 in the same cycle: no capture, because net_ri was 0. The next packet can be accepted one cycle later.
  - Write of addr 2 in the same cycle as a send: dropped, because out_full was 1 at that edge.
  - Status read in the same cycle as a state change returns the pre-edge value.
- Reset mid-operation: any buffered packet is discarded at the reset edge. While reset=1, outputs take their reset values: net_so=0, net_ri=1, d_out=0.
- Throughput: one injected packet per 2 cycles at best (write, then send). Ejection also needs a PE read between packets.

Test Plan:
1. Reset, then read addr 1 and addr 3 -> d_out=0 both; net_ri=1, net_so=0.
2. Write addr 2 with 0x8000_0000_0000_00AA, net_ro=1 -> net_so=1 only in the cycle net_polarity=1; net_do=0x8000_0000_0000_00AA; then addr 3 reads 0.
3. Write addr 2 twice back-to-back with net_ro=0 (0x1, then 0x2) -> net_do stays 0x1, addr 3 reads 1; raise net_ro -> sends 0x1 in the first cycle net_polarity=0.
4. Router drives net_si=1 with 0x1234 -> next cycle net_ri=0, addr 1 reads 1; read addr 0 -> d_out=0x1234 next cycle, net_ri=1 after that edge.
5. net_si=1 with 0x55 while in_full=1 holding 0x1234 -> in_buf unchanged; addr 0 read returns 0x1234.
6. Assert reset with both buffers full -> next cycle net_so=0, net_ri=1, addr 1 and addr 3 read 0.
